// File: rtl/synth_pkg.sv
// synth_pkg: shared widths, DAC constants, output-stage FSM states and frame builder
package synth_pkg;
  localparam int SUM_W = 14;
  localparam int DAC_W = 12;
  localparam int FRAME_W = 16;
  localparam logic [DAC_W-1:0] DAC_MAX = 12'd4095;
  localparam logic [1:0] PD_NORMAL = 2'b00;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  function automatic logic [FRAME_W-1:0] dac_frame(input logic [DAC_W-1:0] d);
    return {2'b00, PD_NORMAL, d};
  endfunction
endpackage

// File: rtl/dac_spi_out_if.sv
// dac_spi_out_if: summed-wave input and SPI pin bundle of the DAC output stage
interface dac_spi_out_if;
  import synth_pkg::*;
  logic [SUM_W-1:0] wave;
  logic sample_tick;
  logic sync_n;
  logic sclk;
  logic sdata;
  logic busy;
  logic overrun;
  modport master (output wave, sample_tick, input sync_n, sclk, sdata, busy, overrun);
  modport slave (input wave, sample_tick, output sync_n, sclk, sdata, busy, overrun);
endinterface

// File: rtl/wave_scale_sat.sv
// wave_scale_sat: right-shifts the summed wave by GAIN_SHIFT and saturates it to the DAC range
module wave_scale_sat
  import synth_pkg::*;
#(
  parameter int GAIN_SHIFT = 2
) (
  input  logic [SUM_W-1:0] wave_i,
  output logic [DAC_W-1:0] dac_o
);
  logic [SUM_W-1:0] scaled;
  // any bit above the DAC width means the scaled word exceeds full scale
  always_comb begin
    scaled = wave_i >> GAIN_SHIFT;
    dac_o = |scaled[SUM_W-1:DAC_W] ? DAC_MAX : scaled[DAC_W-1:0];
  end
endmodule

// File: rtl/dac_spi_out.sv
// dac_spi_out: captures the summed wave on each sample tick and shifts it out as a 16-bit SPI DAC frame
module dac_spi_out
  import synth_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int GAIN_SHIFT = 2
) (
  input logic clk,
  input logic rst_n,
  dac_spi_out_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  state_t state_q;
  logic [DW-1:0] div_q;
  logic [4:0] hp_q;
  logic [FRAME_W-1:0] sr_q;
  logic sync_n_q, sclk_q, busy_q, overrun_q;
  logic [DAC_W-1:0] dac;
  logic [FRAME_W-1:0] frame_d;
  logic half_end;
  wave_scale_sat #(.GAIN_SHIFT(GAIN_SHIFT)) u_scale (.wave_i(bus.wave), .dac_o(dac));
  assign frame_d = dac_frame(dac);
  assign half_end = div_q == DW'(CLK_DIV - 1);
  // frame FSM: divider sets the sclk half-period, sdata is the shift register MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q <= '0;
      hp_q <= '0;
      sr_q <= '0;
      sync_n_q <= 1'b1;
      sclk_q <= 1'b1;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.sample_tick && state_q != IDLE;
      case (state_q)
        IDLE: if (bus.sample_tick) begin
          sr_q <= frame_d;
          sync_n_q <= 1'b0;
          busy_q <= 1'b1;
          div_q <= '0;
          hp_q <= '0;
          state_q <= SHIFT;
        end
        SHIFT: if (half_end) begin
          div_q <= '0;
          sclk_q <= ~sclk_q;
          hp_q <= hp_q + 5'd1;
          if (!sclk_q) begin
            if (hp_q == 5'd31) begin
              sync_n_q <= 1'b1;
              sr_q <= '0;
              state_q <= GAP;
            end else sr_q <= {sr_q[FRAME_W-2:0], 1'b0};
          end
        end else div_q <= div_q + DW'(1);
        GAP: if (half_end) begin
          div_q <= '0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end else div_q <= div_q + DW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.sync_n = sync_n_q;
  assign bus.sclk = sclk_q;
  assign bus.sdata = sr_q[FRAME_W-1];
  assign bus.busy = busy_q;
  assign bus.overrun = overrun_q;
endmodule

// File: doc/dac_spi_out.md
# dac_spi_out

Output stage of the synth voice path: consumes the 14-bit summed wave from the voice summer, captures it on each sample-rate tick, scales and saturates it to 12 bits, and shifts it out as a 16-bit SPI frame to an external 12-bit DAC (DAC121S101-style: data sampled on SCLK falling edge). It is the last block between the mixed audio word and the board pins.

## Interface
- `CLK_DIV`, 2: `clk` cycles per SCLK half-period; legal values are 1 or more.
- `GAIN_SHIFT`, 2: right-shift applied to `wave` before saturation; legal range 0–4.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `wave` input, 14 bits: unsigned summed wave from the summer (max 13·1023 = 13299).
- `sample_tick` input, 1 bit: one-cycle pulse at the audio sample rate.
- `sync_n` output, 1 bit: DAC frame select, active-low.
- `sclk` output, 1 bit: serial clock; idles high.
- `sdata` output, 1 bit: serial data, MSB first.
- `busy` output, 1 bit: high whenever the block is not in IDLE.
- `overrun` output, 1 bit: one-cycle pulse when a tick is dropped.

## Operation
- Scaling: `scaled = wave >> GAIN_SHIFT` (14-bit). If `scaled > 4095`, `dac = 4095`; otherwise `dac = scaled[11:0]`. Frame is `{2'b00 don't-care, 2'b00 normal mode, dac[11:0]}`.
- At the default settings `dac` never clips (13299 >> 2 = 3324). Saturation logic is still mandatory.
- FSM states are IDLE, SHIFT and GAP.
- IDLE with `sample_tick=1`: latch `wave` from the same cycle and load the 16-bit shift register. Set `sync_n=0` and `sdata=frame[15]`. Clear the bit counter and divider, then go to SHIFT.
- SHIFT: a divider counts `CLK_DIV` cycles per half-period, then toggles `sclk`.
  - On each falling toggle, the DAC samples `sdata`.
  - On each rising toggle, the next bit is presented on `sdata`.
  - After the 16th falling edge and its following rising edge (32 half-periods total), set `sync_n=1` and `sdata=0`, then go to GAP.
- GAP: hold for `CLK_DIV` cycles with `sync_n` high, then go to IDLE.
- `sample_tick` in SHIFT or GAP: ignored, and `overrun` pulses high for exactly 1 cycle. The frame in flight is unaffected, and no tick is queued.
- A tick in the same cycle as the GAP→IDLE transition counts as an overrun.
- Any tick sampled while the state is IDLE starts a frame.
- `wave` is only sampled at the accept cycle. Changes during a frame have no effect.

## Timing
- Reset values (asynchronous, on `rst_n` low): `sync_n=1`, `sclk=1`, `sdata=0`, `busy=0`, `overrun=0`, state IDLE, counters 0.
- Reset mid-frame aborts immediately. Outputs go to reset values with no partial completion.
- All outputs are registered.
- Tick accepted on edge E:
  - `sync_n` falls and `busy` rises, both visible after E.
  - The first `sclk` fall comes `CLK_DIV` cycles after E.
  - `sync_n` rises `32·CLK_DIV` cycles after E.
  - `busy` falls `33·CLK_DIV` cycles after E.
- With `CLK_DIV=2`: SCLK = clk/4, frame = 64 cycles, busy for 66 cycles.
- Minimum sustainable tick period is `33·CLK_DIV + 1` cycles.
- `sdata` is stable for a full half-period before and after every falling `sclk` edge.

## Structure
- Shared package `synth_pkg` holds:
  - `SUM_W=14`, `DAC_W=12`, `FRAME_W=16`, `DAC_MAX=4095`.
  - The state enum for IDLE, SHIFT and GAP.
  - The power-down mode constant `2'b00`.
- One sub-module, `wave_scale_sat`: combinational shift and saturate from 14 to 12 bits, parameterised by `GAIN_SHIFT`. It is reusable by any later output-stage variant (e.g. PWM).
- The FSM, divider, bit counter and shift register stay in `dac_spi_out`.

## Test plan
- Zero word: `wave=0`, one tick → 16 bits captured on `sclk` falls equal `0x0000`. `sync_n` is low for exactly 64 cycles with `CLK_DIV=2`.
- Full-scale, default gain: `wave=13299`, `GAIN_SHIFT=2` → frame `0x0CFC` MSB-first, with no saturation.
- Saturation: `GAIN_SHIFT=0`, `wave=5000` → frame `0x0FFF`. Then `wave=4095` → `0x0FFF`, and `wave=4094` → `0x0FFE`.
- Overrun: tick accepted, then a second tick 10 cycles later → `overrun` high for exactly 1 cycle. The first frame is bit-exact, and no second frame starts until a tick arrives after `busy` falls.
- Back-to-back: ticks every 67 cycles (`CLK_DIV=2`) with `wave` alternating 0x0004/0x3FFC → frames 0x0001 then 0x0FFF, and `overrun` never asserts. At a 66-cycle period, every second tick raises `overrun`.
- Reset mid-frame: drop `rst_n` after the 7th `sclk` fall → the same cycle shows `sync_n=1`, `sclk=1`, `sdata=0`, `busy=0`. After release, a fresh tick produces a complete, correct frame.
